capture_buffer: RTL



---
 rtl/capture_buffer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/capture_buffer.sv
// Capture sequencer and circular sample memory beside the multi-level trigger:
// pre-trigger fill, arm, backdated trigger point, post-trigger capture, ordered readout.
module capture_buffer #(
  parameter int dsize    = 32,
  parameter int addr_w   = 10,
  parameter int trig_lat = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [dsize-1:0]  dinput,
  input  logic              sample_en,
  input  logic              start,
  input  logic              abort,
  input  logic [addr_w-1:0] pretrig_count,
  input  logic [addr_w-1:0] posttrig_count,
  input  logic              triggered,
  output logic              trig_arm,
  output logic              trig_abort,
  output logic              trig_ignore,
  output logic              busy,
  output logic [addr_w-1:0] trig_addr,
  output logic [dsize-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last
);

  localparam int DEPTH = 2 ** addr_w;
  localparam logic [addr_w:0]   DEPTH_V = {1'b1, {addr_w{1'b0}}};
  localparam logic [addr_w:0]   ONE_W   = {{addr_w{1'b0}}, 1'b1};
  localparam logic [addr_w-1:0] ONE_A   = {{(addr_w-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, PREFILL, WAIT_TRIG, POST, READOUT} state_t;

  state_t state, state_nxt;

  logic [dsize-1:0]  mem [DEPTH];
  logic [addr_w-1:0] wr_ptr, rd_addr, pre;
  logic [addr_w:0]   fill, post, post_cnt, remaining, room, post_clamp, len;
  logic              trig_q, trig_rise, rd_primed;
  logic              wr_en, rd_issue, rd_accept, arm_nxt, abort_nxt;

  assign trig_ignore = ~sample_en;
  assign busy        = (state != IDLE);
  assign trig_rise   = triggered & ~trig_q;
  assign wr_en       = sample_en && (state == PREFILL || state == WAIT_TRIG || state == POST);
  assign rd_accept   = rd_valid & rd_ready;
  assign rd_issue    = (state == READOUT) && rd_primed && (remaining != '0) && (!rd_valid || rd_ready);
  assign room        = DEPTH_V - {1'b0, pretrig_count};
  assign post_clamp  = ({1'b0, posttrig_count} > room) ? room : {1'b0, posttrig_count};
  assign len         = {1'b0, pre} + post;

  always_comb begin
    state_nxt = state;
    arm_nxt   = 1'b0;
    abort_nxt = 1'b0;
    case (state)
      IDLE:      if (start) state_nxt = PREFILL;
      PREFILL:   if (fill == {1'b0, pre}) begin
                   state_nxt = WAIT_TRIG;
                   arm_nxt   = 1'b1;
                 end
      WAIT_TRIG: if (trig_rise) state_nxt = (post == '0) ? READOUT : POST;
      POST:      if (post_cnt == post) state_nxt = READOUT;
      READOUT:   if ((!rd_primed && len == '0) || (rd_accept && rd_last)) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      arm_nxt   = 1'b0;
      abort_nxt = (state == WAIT_TRIG);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      trig_arm   <= 1'b0;
      trig_abort <= 1'b0;
    end else begin
      state      <= state_nxt;
      trig_arm   <= arm_nxt;
      trig_abort <= abort_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= dinput;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_q    <= 1'b0;
      pre       <= '0;
      post      <= '0;
      wr_ptr    <= '0;
      fill      <= '0;
      post_cnt  <= '0;
      trig_addr <= '0;
      rd_addr   <= '0;
      remaining <= '0;
      rd_primed <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
    end else begin
      trig_q <= triggered;
      if (state == IDLE && start) begin
        pre    <= pretrig_count;
        post   <= post_clamp;
        wr_ptr <= '0;
        fill   <= '0;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + ONE_A;
        if (fill != DEPTH_V) fill <= fill + ONE_W;
      end
      // trigger point is backdated by the trigger pipeline latency
      if (state == WAIT_TRIG && trig_rise && !abort) begin
        trig_addr <= wr_ptr - addr_w'(trig_lat + 1);
        post_cnt  <= '0;
      end
      if (state == POST && wr_en && post_cnt != post) post_cnt <= post_cnt + ONE_W;

      if (state != READOUT) begin
        rd_primed <= 1'b0;
      end else if (!rd_primed) begin
        rd_primed <= 1'b1;
        rd_addr   <= trig_addr - pre + ONE_A;
        remaining <= len;
      end
      // rd_data doubles as the synchronous read register, so a stall simply holds it
      if (rd_issue) begin
        rd_data   <= mem[rd_addr];
        rd_valid  <= 1'b1;
        rd_last   <= (remaining == ONE_W);
        rd_addr   <= rd_addr + ONE_A;
        remaining <= remaining - ONE_W;
      end else if (rd_accept) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
      if (abort && state != IDLE) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
    end
  end

endmodule
